// File: rtl/run_monitor_if.sv
// Bus bundle between the mipse core side and the run monitor:
// core trace and checkpoint setup in, run status and counters out.
interface run_monitor_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NCHK   = 2,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned HIT_W  = 16
);
    logic                     clr;
    logic                     en;
    logic [DATA_W-1:0]        pc;
    logic [DATA_W-1:0]        daddr;
    logic [DATA_W-1:0]        wdata;
    logic                     we;
    logic [NCHK*DATA_W-1:0]   chk_pc;
    logic [NCHK-1:0]          chk_en;

    logic [1:0]               state;
    logic                     done;
    logic                     timeout;
    logic [DATA_W-1:0]        exit_val;
    logic [CNT_W-1:0]         cycles;
    logic [NCHK*HIT_W-1:0]    hits;
    logic [NCHK-1:0]          chk_hit;

    // Driver side: bench, debug port or host.
    modport master (
        output clr, en, pc, daddr, wdata, we, chk_pc, chk_en,
        input  state, done, timeout, exit_val, cycles, hits, chk_hit
    );

    // Monitor side.
    modport slave (
        input  clr, en, pc, daddr, wdata, we, chk_pc, chk_en,
        output state, done, timeout, exit_val, cycles, hits, chk_hit
    );
endinterface

// File: rtl/run_monitor.sv
// Run supervisor for the mipse core: detects the exit store, counts run cycles,
// counts PC checkpoint hits per channel and stops the run at a cycle limit.
module run_monitor #(
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          NCHK       = 2,
    parameter int unsigned          CNT_W      = 32,
    parameter int unsigned          HIT_W      = 16,
    parameter logic [DATA_W-1:0]    EXIT_ADDR  = 32'h7fff,
    parameter longint unsigned      MAX_CYCLES = 100000
) (
    input logic          clk,
    input logic          rst,
    run_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2,
        StTout = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CYCLES);
    localparam logic [HIT_W-1:0] HitMax = {HIT_W{1'b1}};

    state_e                  state_q, state_d;
    logic                    done_q, done_d;
    logic                    timeout_q, timeout_d;
    logic [DATA_W-1:0]       exit_val_q, exit_val_d;
    logic [CNT_W-1:0]        cycles_q, cycles_d;
    logic [NCHK*HIT_W-1:0]   hits_q, hits_d;
    logic [NCHK-1:0]         chk_hit_q, chk_hit_d;

    // Next state: clear beats the FSM; counting only on RUN cycles with en high.
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        exit_val_d = exit_val_q;
        cycles_d   = cycles_q;
        hits_d     = hits_q;
        chk_hit_d  = '0;

        if (bus.clr) begin
            state_d    = StIdle;
            done_d     = 1'b0;
            timeout_d  = 1'b0;
            exit_val_d = '0;
            cycles_d   = '0;
            hits_d     = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.en) state_d = StRun;
                end
                StRun: begin
                    if (bus.en) begin
                        cycles_d = cycles_q + CNT_W'(1);
                        // Overlapping channels all count; saturate instead of wrapping.
                        for (int i = 0; i < int'(NCHK); i++) begin
                            if (bus.chk_en[i] && bus.pc == bus.chk_pc[i*DATA_W +: DATA_W]) begin
                                chk_hit_d[i] = 1'b1;
                                if (hits_q[i*HIT_W +: HIT_W] != HitMax) begin
                                    hits_d[i*HIT_W +: HIT_W] =
                                        hits_q[i*HIT_W +: HIT_W] + HIT_W'(1);
                                end
                            end
                        end
                        // Exit takes priority over the limit when both land together.
                        if (bus.we && bus.daddr == EXIT_ADDR) begin
                            exit_val_d = bus.wdata;
                            done_d     = 1'b1;
                            state_d    = StDone;
                        end else if (cycles_d == MaxCnt) begin
                            timeout_d = 1'b1;
                            state_d   = StTout;
                        end
                    end
                end
                StDone, StTout: begin
                end
                default: begin
                end
            endcase
        end
    end

    // State and result registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            exit_val_q <= '0;
            cycles_q   <= '0;
            hits_q     <= '0;
            chk_hit_q  <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            exit_val_q <= exit_val_d;
            cycles_q   <= cycles_d;
            hits_q     <= hits_d;
            chk_hit_q  <= chk_hit_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.done     = done_q;
    assign bus.timeout  = timeout_q;
    assign bus.exit_val = exit_val_q;
    assign bus.cycles   = cycles_q;
    assign bus.hits     = hits_q;
    assign bus.chk_hit  = chk_hit_q;

endmodule

// File: tb/tb_run_monitor.sv
// Scoreboard bench for run_monitor (HIT_W=3, MAX_CYCLES=20): each cycle's
// expected snapshot is queued as stimulus is driven and popped after the edge.
module tb_run_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    run_monitor_if #(.DATA_W(32), .NCHK(2), .CNT_W(32), .HIT_W(3)) bus ();

    run_monitor #(
        .DATA_W(32), .NCHK(2), .CNT_W(32), .HIT_W(3),
        .EXIT_ADDR(32'h7fff), .MAX_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        dn;
        logic        to;
        logic [31:0] ev;
        logic [31:0] cy;
        logic [5:0]  hi;
        logic [1:0]  ch;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic snap_t snap();
        snap_t s;
        s.st = bus.state;
        s.dn = bus.done;
        s.to = bus.timeout;
        s.ev = bus.exit_val;
        s.cy = bus.cycles;
        s.hi = bus.hits;
        s.ch = bus.chk_hit;
        return s;
    endfunction

    function automatic snap_t mk(input logic [1:0] st, input logic dn, input logic to,
                                 input logic [31:0] ev, input logic [31:0] cy,
                                 input int h0, input int h1, input logic [1:0] ch);
        snap_t s;
        s.st = st;
        s.dn = dn;
        s.to = to;
        s.ev = ev;
        s.cy = cy;
        s.hi = {3'(h1), 3'(h0)};
        s.ch = ch;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("st=%0d dn=%0b to=%0b ev=%h cy=%0d h1=%0d h0=%0d ch=%b",
                         s.st, s.dn, s.to, s.ev, s.cy, s.hi[5:3], s.hi[2:0], s.ch);
    endfunction

    task automatic step(input logic en, input logic we, input logic [31:0] da,
                        input logic [31:0] wd, input logic [31:0] pc);
        bus.en    = en;
        bus.we    = we;
        bus.daddr = da;
        bus.wdata = wd;
        bus.pc    = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t got, e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(i < 2 ? mk(0, 0, 0, 0, 0, 0, 0, 2'b00) : mk(1, 0, 0, 0, 0, 0, 0, 2'b00));
            if (i == 0) begin
                @(posedge clk);
                #1;
            end else begin
                rst = 1'b0;
                step(i == 2, 1'b0, 32'h0, 32'h0, 32'h0);
            end
            got = snap();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    // Starts in RUN with cycles=0; cycle 3 has daddr match without we, cycle 5 a near-miss address.
    task automatic test_exit();
        snap_t got, e;
        logic w;
        logic [31:0] a, d;
        for (int i = 1; i <= 12; i++) begin
            w = (i == 5 || i >= 10);
            a = (i == 5) ? 32'h0001_7fff : 32'h7fff;
            d = (i >= 11) ? 32'h5678 : (i == 5 ? 32'hdead : 32'h1234);
            bus.clr = (i == 12);
            if (i == 12)      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00));
            else if (i >= 10) exp_q.push_back(mk(2, 1, 0, 32'h1234, 10, 0, 0, 2'b00));
            else              exp_q.push_back(mk(1, 0, 0, 0, i, 0, 0, 2'b00));
            step(1'b1, w, a, d, 32'h0);
            got = snap();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL exit[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
        bus.clr = 1'b0;
    endtask

    task automatic test_checkpoints();
        snap_t got, e;
        logic [31:0] pc;
        logic hit0, hit1;
        int h0 = 0, h1 = 0;
        bus.chk_pc = {32'h30, 32'h30};
        bus.chk_en = 2'b01;
        for (int i = 0; i <= 13; i++) begin
            bus.clr = (i == 13);
            pc = (i % 2 == 1 || i > 10 || i == 0) ? 32'h30 : 32'h34;
            if (i > 10) bus.chk_en = 2'b11;
            if (i == 0) begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'b00));
            end else if (i == 13) begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00));
            end else begin
                hit0 = (pc == 32'h30);
                hit1 = (i > 10);
                h0 += int'(hit0);
                h1 += int'(hit1);
                exp_q.push_back(mk(1, 0, 0, 0, i, h0, h1, {hit1, hit0}));
            end
            step(1'b1, 1'b0, 32'h0, 32'h0, pc);
            got = snap();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL chk[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
        bus.clr = 1'b0;
        bus.chk_en = 2'b00;
    endtask

    task automatic test_timeout();
        snap_t got, e;
        logic ex;
        for (int i = 0; i <= 22; i++) begin
            bus.clr = (i == 22);
            ex = (i == 21);
            if (i == 22)      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00));
            else if (i >= 20) exp_q.push_back(mk(3, 0, 1, 0, 20, 0, 0, 2'b00));
            else              exp_q.push_back(mk(1, 0, 0, 0, i, 0, 0, 2'b00));
            step(1'b1, ex, 32'h7fff, 32'h9999, 32'h0);
            got = snap();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL tout[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
        bus.clr = 1'b0;
    endtask

    task automatic test_tie();
        snap_t got, e;
        for (int i = 0; i <= 21; i++) begin
            bus.clr = (i == 21);
            if (i == 21)      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00));
            else if (i == 20) exp_q.push_back(mk(2, 1, 0, 32'habcd, 20, 0, 0, 2'b00));
            else              exp_q.push_back(mk(1, 0, 0, 0, i, 0, 0, 2'b00));
            step(1'b1, i == 20, 32'h7fff, 32'habcd, 32'h0);
            got = snap();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL tie[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
        bus.clr = 1'b0;
    endtask

    // One hit, a 4-cycle pause carrying a would-be hit and exit, then 8 more hits.
    task automatic test_pause_sat();
        snap_t got, e;
        logic en;
        logic [31:0] pc;
        int h;
        bus.chk_pc = {32'h0, 32'h40};
        bus.chk_en = 2'b01;
        for (int i = 0; i <= 16; i++) begin
            bus.clr = (i == 16);
            en = !(i >= 4 && i <= 7);
            pc = (i >= 3) ? 32'h40 : 32'h0;
            if (i == 0)      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'b00));
            else if (i < 3)  exp_q.push_back(mk(1, 0, 0, 0, i, 0, 0, 2'b00));
            else if (i == 3) exp_q.push_back(mk(1, 0, 0, 0, 3, 1, 0, 2'b01));
            else if (i < 8)  exp_q.push_back(mk(1, 0, 0, 0, 3, 1, 0, 2'b00));
            else if (i < 16) begin
                h = (i - 6 > 7) ? 7 : i - 6;
                exp_q.push_back(mk(1, 0, 0, 0, i - 4, h, 0, 2'b01));
            end else         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00));
            step(en, !en, 32'h7fff, 32'h1111, pc);
            got = snap();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pause[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
        bus.clr = 1'b0;
        bus.chk_en = 2'b00;
    endtask

    task automatic test_async_reset();
        snap_t got, e;
        for (int i = 0; i <= 10; i++) begin
            if (i <= 7) begin
                exp_q.push_back(mk(1, 0, 0, 0, i, 0, 0, 2'b00));
                step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
            end else if (i == 8) begin
                // Mid-cycle assertion: outputs must clear before the next edge.
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00));
                #2 rst = 1'b1;
                #1;
            end else begin
                if (i == 9) begin
                    @(posedge clk);
                    #1 rst = 1'b0;
                end
                exp_q.push_back(i == 9 ? mk(0, 0, 0, 0, 0, 0, 0, 2'b00)
                                       : mk(1, 0, 0, 0, 0, 0, 0, 2'b00));
                step(i == 10, 1'b0, 32'h0, 32'h0, 32'h0);
            end
            got = snap();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL arst[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
        bus.clr = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        bus.clr = 1'b0;
    endtask

    initial begin
        bus.clr    = 1'b0;
        bus.en     = 1'b0;
        bus.we     = 1'b0;
        bus.pc     = '0;
        bus.daddr  = '0;
        bus.wdata  = '0;
        bus.chk_pc = '0;
        bus.chk_en = '0;
        test_reset();
        test_exit();
        test_checkpoints();
        test_timeout();
        test_tie();
        test_pause_sat();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
